// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes,
// the row/column key map, and the FSM / scan-result encodings.
package keypad_pkg;

    localparam logic [3:0] KEY_RESET  = 4'd10;
    localparam logic [3:0] KEY_EQUALS = 4'd11;
    localparam logic [3:0] KEY_CLEAR  = 4'd12;
    localparam logic [3:0] KEY_MUL    = 4'd13;
    localparam logic [3:0] KEY_SUB    = 4'd14;
    localparam logic [3:0] KEY_ADD    = 4'd15;

    typedef enum logic [1:0] {
        SEARCH,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } scan_t;

    function automatic logic [3:0] key_map(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'd1;
            4'h1:    k = 4'd2;
            4'h2:    k = 4'd3;
            4'h3:    k = KEY_ADD;
            4'h4:    k = 4'd4;
            4'h5:    k = 4'd5;
            4'h6:    k = 4'd6;
            4'h7:    k = KEY_SUB;
            4'h8:    k = 4'd7;
            4'h9:    k = 4'd8;
            4'hA:    k = 4'd9;
            4'hB:    k = KEY_MUL;
            4'hC:    k = KEY_RESET;
            4'hD:    k = 4'd0;
            4'hE:    k = KEY_EQUALS;
            default: k = KEY_CLEAR;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
// Resets to all-ones, the idle (pulled-up) level of the rows.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sampling, scan classification
// and press/release debouncing into one strobe per physical press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock1000,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] number,
    output logic       buttonPressed,
    output logic       keyStrobe
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [3:0]    rows_sync;
    logic [1:0]    col_idx;
    logic [1:0]    col_nxt;
    logic [SW-1:0] settle;
    logic [15:0]   hits;
    logic          eval;

    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rcnt;

    scan_t         result;
    logic [3:0]    code;
    logic [4:0]    ones;
    logic [3:0]    idx;

    keypad_sync u_sync (
        .clk   (clock1000),
        .reset (reset),
        .d     (rows),
        .q     (rows_sync)
    );

    assign col_nxt = col_idx + 2'd1;

    // hits holds one nibble per column, bit = row, 1 = key closed
    always_ff @(posedge clock1000) begin
        if (reset) begin
            cols    <= 4'b1110;
            col_idx <= '0;
            settle  <= '0;
            hits    <= '0;
            eval    <= 1'b0;
        end else begin
            eval <= 1'b0;
            if (settle == S_LAST) begin
                hits[{col_idx, 2'b00} +: 4] <= ~rows_sync;
                settle  <= '0;
                col_idx <= col_nxt;
                cols    <= ~(4'b0001 << col_nxt);
                eval    <= (col_idx == 2'd3);
            end else begin
                settle <= settle + SW'(1);
            end
        end
    end

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (hits[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end
        end
        if (ones == 5'd0)
            result = NONE;
        else if (ones == 5'd1)
            result = SINGLE;
        else
            result = MULTI;
        code = key_map(idx[1:0], idx[3:2]);
    end

    always_ff @(posedge clock1000) begin
        if (reset) begin
            state         <= SEARCH;
            cand          <= '0;
            cnt           <= '0;
            rcnt          <= '0;
            number        <= '0;
            buttonPressed <= 1'b0;
            keyStrobe     <= 1'b0;
        end else begin
            keyStrobe <= 1'b0;
            if (eval) begin
                unique case (state)
                    SEARCH: begin
                        if (result == SINGLE) begin
                            cand <= code;
                            if (DEBOUNCE_SCANS == 1) begin
                                number        <= code;
                                buttonPressed <= 1'b1;
                                keyStrobe     <= 1'b1;
                                cnt           <= '0;
                                state         <= HELD;
                            end else begin
                                cnt   <= C_ONE;
                                state <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (result == SINGLE && code == cand) begin
                            if (cnt >= C_LAST) begin
                                number        <= cand;
                                buttonPressed <= 1'b1;
                                keyStrobe     <= 1'b1;
                                cnt           <= '0;
                                state         <= HELD;
                            end else begin
                                cnt <= cnt + C_ONE;
                            end
                        end else if (result == SINGLE) begin
                            cand <= code;
                            cnt  <= C_ONE;
                        end else begin
                            cnt   <= '0;
                            state <= SEARCH;
                        end
                    end
                    HELD: begin
                        if (result == NONE) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                buttonPressed <= 1'b0;
                                state         <= SEARCH;
                            end else begin
                                rcnt  <= C_ONE;
                                state <= REL_DB;
                            end
                        end
                    end
                    REL_DB: begin
                        if (result == NONE) begin
                            if (rcnt >= C_LAST) begin
                                buttonPressed <= 1'b0;
                                rcnt          <= '0;
                                state         <= SEARCH;
                            end else begin
                                rcnt <= rcnt + C_ONE;
                            end
                        end else begin
                            rcnt  <= '0;
                            state <= HELD;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule
